// File: rtl/diff_burst_rx.sv
// diff_burst_rx: receive side of a tristated differential pad pair.
// Each clk edge samples (i, ib) and decodes it as a valid bit (i != ib, bit = i)
// or as invalid (undriven or common-mode). A run of PRE_LEN valid-0 samples
// opens a burst. The next BL valid samples are then collected LSB first and
// delivered on data together with a one-cycle data_valid pulse. A single
// postamble sample, expected to be valid-0, follows every burst.
// Optional feature macro: DIFF_RX_ERRCNT_EN adds a saturating error counter
// that is exposed on err_cnt.
module diff_burst_rx #(
  parameter int BL      = 8,
  parameter int PRE_LEN = 2,
  parameter int ERR_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          i,
  input  logic          ib,
  output logic [BL-1:0] data,
  output logic          data_valid,
  output logic          err_invalid,
  output logic          err_postamble,
  output logic          busy
`ifdef DIFF_RX_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam int IDX_W = $clog2(BL) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_POST = 2'd3
  } state_t;

  // Refuse to elaborate with parameters outside the supported range.
  if (BL < 2 || BL > 32 || PRE_LEN < 1 || PRE_LEN > 15 || ERR_W < 1) begin : g_bad_param
    $error("diff_burst_rx: parameter out of range");
  end

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [BL-1:0]    shreg_q;
  logic [BL-1:0]    shreg_d;
  logic [BL-1:0]    data_q;
  logic             data_valid_q;
  logic             err_invalid_q;
  logic             err_postamble_q;
  logic             busy_q;

  logic s_vld;
  logic s_zero;
  logic last_bit;

  assign s_vld    = i ^ ib;
  assign s_zero   = s_vld & ~i;
  assign last_bit = (idx_q == IDX_W'(BL - 1));

  // Shift register with the current sample written at position idx.
  always_comb begin
    shreg_d = shreg_q;
    for (int k = 0; k < BL; k++) begin
      if (idx_q == IDX_W'(k)) shreg_d[k] = i;
    end
  end

  // Framing FSM. All outputs are registered, and pulse outputs default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shreg_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      err_invalid_q   <= 1'b0;
      err_postamble_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      err_invalid_q   <= 1'b0;
      err_postamble_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en && s_zero) begin
            busy_q <= 1'b1;
            if (PRE_LEN == 1) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              state_q <= S_PRE;
              cnt_q   <= 4'd1;
            end
          end
        end
        S_PRE: begin
          if (!en || !s_zero) begin
            // A short preamble is dropped without raising an error.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q + 4'd1 == 4'(PRE_LEN)) begin
            state_q <= S_DATA;
            cnt_q   <= cnt_q + 4'd1;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (!en) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (!s_vld) begin
            err_invalid_q <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
          end else begin
            shreg_q <= shreg_d;
            if (last_bit) begin
              data_q       <= shreg_d;
              data_valid_q <= 1'b1;
              state_q      <= S_POST;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_POST: begin
          // The postamble sample is never reused as a preamble sample.
          if (en && !s_zero) err_postamble_q <= 1'b1;
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign err_invalid   = err_invalid_q;
  assign err_postamble = err_postamble_q;
  assign busy          = busy_q;

`ifdef DIFF_RX_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // Saturating count of error pulses. It is updated on the cycle after each pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((err_invalid_q || err_postamble_q) && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_diff_burst_rx.sv
// Directed bench for diff_burst_rx with BL=8 and PRE_LEN=2.
module tb_diff_burst_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sig_i;
  logic       sig_ib;
  logic [7:0] data;
  logic       data_valid;
  logic       err_invalid;
  logic       err_postamble;
  logic       busy;
`ifdef DIFF_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  diff_burst_rx #(.BL(8), .PRE_LEN(2), .ERR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i            (sig_i),
    .ib           (sig_ib),
    .data         (data),
    .data_valid   (data_valid),
    .err_invalid  (err_invalid),
    .err_postamble(err_postamble),
    .busy         (busy)
`ifdef DIFF_RX_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample at the falling edge. Return 1 time unit after the rising edge that consumes it.
  task automatic put(input logic a, input logic b);
    @(negedge clk);
    sig_i  = a;
    sig_ib = b;
    @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic v);
    put(v, ~v);
  endtask

  // Drive the preamble and the first n data bits of w, checking that no pulse appears.
  task automatic partial(input logic [7:0] w, input int n, input string tag);
    put(1'b0, 1'b1);
    chk({tag, "_pre1_busy"}, busy, 1);
    put(1'b0, 1'b1);
    chk({tag, "_pre2_busy"}, busy, 1);
    for (int k = 0; k < n; k++) begin
      put_bit(w[k]);
      chk({tag, "_bit_pulses"}, {data_valid, err_invalid, err_postamble}, 3'b000);
    end
  endtask

  // Drive a full burst and check delivery in the cycle that coincides with POST.
  task automatic burst(input logic [7:0] w, input string tag);
    partial(w, 7, tag);
    put_bit(w[7]);
    chk({tag, "_valid"}, data_valid, 1);
    chk({tag, "_data"}, data, w);
    chk({tag, "_busy_post"}, busy, 1);
    chk({tag, "_noerr"}, {err_invalid, err_postamble}, 2'b00);
  endtask

  initial begin
    // 1. Reset with random pair values, then idle on (1,1).
    rst    = 1'b1;
    en     = 1'b1;
    sig_i  = 1'($urandom_range(0, 1));
    sig_ib = 1'($urandom_range(0, 1));
    repeat (3) begin
      @(negedge clk);
      sig_i  = 1'($urandom_range(0, 1));
      sig_ib = 1'($urandom_range(0, 1));
    end
    #1;
    chk("rst_outputs", {data, data_valid, err_invalid, err_postamble, busy}, 0);
`ifdef DIFF_RX_ERRCNT_EN
    chk("rst_errcnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) put(1'b1, 1'b1);
    chk("idle11_outputs", {data, data_valid, err_invalid, err_postamble, busy}, 0);

    // 2. Clean 0xA5 burst.
    burst(8'hA5, "a5");
    put(1'b0, 1'b1);
    chk("a5_post_valid", data_valid, 0);
    chk("a5_post_err", err_postamble, 0);
    chk("a5_post_busy", busy, 0);
    chk("a5_post_data", data, 8'hA5);

    // 3. Invalid sample after 4 data bits.
    put(1'b1, 1'b1);
    partial(8'h0F, 4, "inv");
    put(1'b1, 1'b1);
    chk("inv_pulse", err_invalid, 1);
    chk("inv_novalid", data_valid, 0);
    chk("inv_busy", busy, 0);
    chk("inv_data_held", data, 8'hA5);
    put(1'b1, 1'b1);
    chk("inv_pulse_width", err_invalid, 0);
`ifdef DIFF_RX_ERRCNT_EN
    chk("inv_errcnt", err_cnt, 1);
`endif

    // 4. 0x3C burst with a bad postamble.
    burst(8'h3C, "pst");
    put(1'b1, 1'b0);
    chk("pst_err", err_postamble, 1);
    chk("pst_valid_width", data_valid, 0);
    put(1'b1, 1'b1);
    chk("pst_err_width", err_postamble, 0);
    chk("pst_data", data, 8'h3C);
`ifdef DIFF_RX_ERRCNT_EN
    chk("pst_errcnt", err_cnt, 2);
`endif

    // 5. Short preamble is dropped silently, then a clean 0xFF burst follows.
    put(1'b0, 1'b1);
    chk("short_busy", busy, 1);
    put(1'b1, 1'b0);
    chk("short_idle", {busy, data_valid, err_invalid, err_postamble}, 4'b0000);
    put(1'b1, 1'b0);
    chk("short_stay", busy, 0);
    burst(8'hFF, "ff");
    put(1'b0, 1'b1);
    chk("ff_post", {busy, err_postamble}, 2'b00);

    // Back-to-back: a new preamble starts immediately after POST.
    burst(8'h42, "b2b");
    put(1'b0, 1'b1);
    chk("b2b_post", {busy, err_postamble, data_valid}, 3'b000);

    // Receiver disabled in the middle of DATA.
    partial(8'h99, 3, "en");
    en = 1'b0;
    put_bit(1'b1);
    chk("en_low", {busy, data_valid, err_invalid, err_postamble}, 4'b0000);
    chk("en_data_held", data, 8'h42);
    put(1'b0, 1'b1);
    chk("en_low_idle", busy, 0);
    en = 1'b1;

    // 6. Asynchronous reset at data bit 5.
    partial(8'h5A, 5, "ar");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {data, data_valid, err_invalid, err_postamble, busy}, 0);
    @(negedge clk);
    rst    = 1'b0;
    sig_i  = 1'b1;
    sig_ib = 1'b1;
    put(1'b1, 1'b1);
    burst(8'h81, "x81");
    put(1'b0, 1'b1);
    chk("x81_data_held", data, 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
